// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t      : sequencer states (IDLE=0, SHIFT=1, FIN=2). Later serial
//                  arithmetic blocks reuse this encoding.
//   count_width  : width of a bit counter that must hold 0..w.
package serial_ripple_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_cell.sv
// full_subtractor: combinational one-bit subtractor cell, the bit-cell
// counterpart of full_adder.
//   a, b       : minuend bit, subtrahend bit
//   borrow_in  : borrow from the next-lower bit
//   diff       : a - b - borrow_in (mod 2)
//   borrow_out : set when a < b + borrow_in
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~a & borrow_in) | (b & borrow_in);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial unsigned subtractor, diff = a - b,
// one bit per clock, LSB first, through a single full_subtractor cell with
// a registered borrow.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled only in IDLE
//   a, b      : minuend / subtrahend, captured when start is accepted
//   busy      : high while bits are being shifted through the cell
//   done      : one-cycle pulse, diff valid
//   diff      : {final borrow, (a - b) mod 2^WIDTH}; two's complement
//   fsm_state : current sequencer state (observation only)
//
// Handshake: start is accepted on a rising edge where the block is IDLE and
// start=1; a and b are captured on that same edge. busy is high for the
// WIDTH following cycles, then done pulses for exactly one cycle with diff
// valid. diff then holds until the next operation's done. start seen while
// busy or during done is ignored; holding start high restarts the block
// each time it returns to IDLE.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff,
    output state_t           fsm_state
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             cell_diff;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor u_cell (
        .a          (a_reg[0]),
        .b          (b_reg[0]),
        .borrow_in  (borrow),
        .diff       (cell_diff),
        .borrow_out (cell_bout)
    );

    assign last_bit  = (count == CW'(WIDTH - 1));
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand shift registers, borrow flop, bit counter, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            borrow  <= 1'b0;
            count   <= '0;
            diff    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= 1'b0;
                        count  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    // Each new difference bit enters at the MSB, so after
                    // WIDTH shifts the first (LSB) bit has reached bit 0.
                    res_reg <= {cell_diff, res_reg[WIDTH-1:1]};
                    borrow  <= cell_bout;
                    count   <= count + CW'(1);
                    // Publish straight from the cell on the last bit so diff
                    // updates on FIN entry and holds through the next SHIFT.
                    if (last_bit) begin
                        diff <= {cell_bout, cell_diff, res_reg[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;
    import serial_ripple_subtractor_pkg::*;

    localparam int W    = 4;
    localparam int MASK = (1 << (W + 1)) - 1;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W:0]   diff;
    state_t       fsm_state;

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int         errors = 0;
    int         checks = 0;
    int         model_diff = 0;   // diff the reference model says is held
    logic [W:0] exp_q[$];

    // Reference: (W+1)-bit two's complement of the integer difference.
    function automatic int ref_diff(input int av, input int bv);
        return (av - bv) & MASK;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called on a falling edge with the block idle. Pulses start for one
    // cycle, then checks busy/done/diff on every cycle of the operation.
    task automatic run_op(input int av, input int bv, input string tag);
        int exp_v;
        exp_v = ref_diff(av, bv);
        a     = W'(av);
        b     = W'(bv);
        start = 1'b1;
        @(negedge clk);                       // cycle 1: first SHIFT cycle
        start = 1'b0;
        a     = W'($urandom);                 // must not disturb the op
        b     = W'($urandom);
        for (int c = 1; c <= W; c++) begin
            check({tag, "_busy"}, int'(busy), 1);
            check({tag, "_nodone"}, int'(done), 0);
            check({tag, "_hold"}, int'(diff), model_diff);
            if (c < W) @(negedge clk);
        end
        @(negedge clk);                       // cycle W+1: result cycle
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy_fin"}, int'(busy), 0);
        check({tag, "_diff"}, int'(diff), exp_v);
        model_diff = exp_v;
        @(negedge clk);
        check({tag, "_done_once"}, int'(done), 0);
        check({tag, "_diff_keep"}, int'(diff), model_diff);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_done;
        int w_cnt;
        int last_done;
        logic [W:0] exp_v;

        // 1: reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            @(negedge clk);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_diff", int'(diff), 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 2, 3: directed values including the range edges
        run_op(9, 3, "a9b3");
        run_op(3, 9, "a3b9");
        run_op(0, 15, "a0b15");
        run_op(15, 0, "a15b0");
        run_op(7, 7, "a7b7");

        // 4: start during SHIFT is ignored
        a = 4'd5; b = 4'd5; start = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                a = 4'd15; b = 4'd0; start = 1'b1;
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                n_done++;
                check("ign_diff", int'(diff), 0);
                check("ign_cycle", c, W + 1);
            end
        end
        check("ign_one_done", n_done, 1);
        model_diff = 0;

        // 5: reset in the middle of an operation
        a = 4'd9; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);                       // cycle 2 of the op
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_diff", int'(diff), 0);
        model_diff = 0;
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op(12, 7, "a12b7");

        // Random operands against the reference model
        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
        end

        // 6: exhaustive with start held high; one result per W+2 cycles
        last_done = 0;
        a = '0; b = '0;
        exp_q.push_back(W'(0) - W'(0));
        exp_q[0] = (W + 1)'(ref_diff(0, 0));
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w_cnt = 0;
            while (!done && w_cnt < 3 * W) begin
                @(negedge clk);
                w_cnt++;
            end
            check("ex_timeout", int'(done), 1);
            if (!done) break;
            if (i > 0) check("ex_spacing", cycle_cnt - last_done, W + 2);
            last_done = cycle_cnt;
            exp_v = exp_q.pop_front();
            check("ex_diff", int'(diff), int'(exp_v));
            if (i < 255) begin
                a = W'((i + 1) >> W);
                b = W'((i + 1) & ((1 << W) - 1));
                exp_q.push_back((W + 1)'(ref_diff((i + 1) >> W, (i + 1) & ((1 << W) - 1))));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
